// File: rtl/vga_fb_prefetch_ctrl_if.sv
// Memory read port and FIFO write port of the frame-buffer prefetch controller.
// master = prefetch controller, slave = memory controller / FIFO side.
interface vga_fb_prefetch_ctrl_if #(
  parameter int unsigned AW = 19,
  parameter int unsigned DW = 16
) ();
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ready;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] fifo_din;
  logic          fifo_write;
  logic          fifo_full;
  logic          fifo_afull;

  modport master (
    output mem_req, mem_addr, fifo_din, fifo_write,
    input  mem_ready, mem_rvalid, mem_rdata, fifo_full, fifo_afull
  );

  modport slave (
    input  mem_req, mem_addr, fifo_din, fifo_write,
    output mem_ready, mem_rvalid, mem_rdata, fifo_full, fifo_afull
  );
endinterface

// File: rtl/vga_fb_prefetch_ctrl.sv
// Frame-buffer prefetch scheduler: sequential memory reads pushed into the VGA pixel FIFO.
// Define VGA_FB_STAT_EN to implement the frame_cnt counter and sticky err_ovf flag.
module vga_fb_prefetch_ctrl #(
  parameter int unsigned   AW         = 19,
  parameter int unsigned   DW         = 16,
  parameter int unsigned   H_RES      = 640,
  parameter int unsigned   V_RES      = 480,
  parameter logic [AW-1:0] BASE_ADDR  = '0,
  parameter int unsigned   MAX_OUTSTD = 4
) (
  input  logic                   clk_sys,
  input  logic                   rst_sys_n,
  input  logic                   enable,
  input  logic                   frame_start,
  vga_fb_prefetch_ctrl_if.master bus,
  output logic                   busy,
  output logic [15:0]            frame_cnt,
  output logic                   err_ovf
);

  localparam int unsigned     FrameWords  = H_RES * V_RES;
  localparam int unsigned     CntW        = $clog2(FrameWords + 1);
  localparam logic [CntW-1:0] FrameWordsC = CntW'(FrameWords);
  localparam logic [3:0]      MaxOutstd   = 4'(MAX_OUTSTD);

  typedef enum logic [1:0] {StIdle, StRun, StWaitEof, StFlush} state_e;

  state_e          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [CntW-1:0] req_cnt_q, req_cnt_d;
  logic [3:0]      outstd_q, outstd_d;
  logic            fifo_write_q, fifo_write_d;
  logic [DW-1:0]   fifo_din_q, fifo_din_d;
  logic            accept, ret_ok;

  always_comb begin
    accept = mem_req_q & bus.mem_ready;
    // Returns with nothing outstanding belong to requests issued before a reset.
    ret_ok = bus.mem_rvalid & (outstd_q != 4'd0);

    state_d      = state_q;
    mem_addr_d   = accept ? mem_addr_q + AW'(1) : mem_addr_q;
    req_cnt_d    = accept ? req_cnt_q + CntW'(1) : req_cnt_q;
    outstd_d     = outstd_q + {3'b000, accept} - {3'b000, ret_ok};
    fifo_write_d = 1'b0;
    fifo_din_d   = fifo_din_q;

    if (ret_ok && (state_q == StRun || state_q == StWaitEof)) begin
      fifo_write_d = 1'b1;
      fifo_din_d   = bus.mem_rdata;
    end

    case (state_q)
      StIdle: begin
        if (frame_start && enable) begin
          state_d    = StRun;
          mem_addr_d = BASE_ADDR;
          req_cnt_d  = '0;
        end
      end
      StRun: begin
        if (frame_start) begin
          state_d = StFlush;
        end else if (accept && req_cnt_d == FrameWordsC) begin
          state_d = StWaitEof;
        end
      end
      StWaitEof: begin
        if (frame_start) begin
          state_d = StFlush;
        end else if (outstd_q == 4'd0) begin
          state_d = StIdle;
        end
      end
      StFlush: begin
        if (outstd_q == 4'd0 && !mem_req_q) begin
          state_d    = StRun;
          mem_addr_d = BASE_ADDR;
          req_cnt_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // A request already on the bus is never retracted, even when leaving RUN.
    if (mem_req_q && !bus.mem_ready) begin
      mem_req_d = 1'b1;
    end else begin
      mem_req_d = (state_d == StRun) && enable && !bus.fifo_afull &&
                  (outstd_d < MaxOutstd) && (req_cnt_d < FrameWordsC);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q      <= StIdle;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= BASE_ADDR;
      req_cnt_q    <= '0;
      outstd_q     <= 4'd0;
      fifo_write_q <= 1'b0;
      fifo_din_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      req_cnt_q    <= req_cnt_d;
      outstd_q     <= outstd_d;
      fifo_write_q <= fifo_write_d;
      fifo_din_q   <= fifo_din_d;
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.fifo_write = fifo_write_q;
  assign bus.fifo_din   = fifo_din_q;
  assign busy           = (state_q != StIdle);

`ifdef VGA_FB_STAT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        err_ovf_q, err_ovf_d;
  logic        frame_done;

  assign frame_done = (state_q == StWaitEof) && (state_d == StIdle);

  always_comb begin
    frame_cnt_d = frame_cnt_q + 16'(frame_done);
    // A write issued into a full FIFO is lost; remember it until reset.
    err_ovf_d   = err_ovf_q | (fifo_write_q & bus.fifo_full);
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      frame_cnt_q <= 16'd0;
      err_ovf_q   <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_ovf   = err_ovf_q;
`else
  logic unused_fifo_full;
  assign unused_fifo_full = bus.fifo_full;
  assign frame_cnt        = 16'd0;
  assign err_ovf          = 1'b0;
`endif

endmodule

// File: tb/tb_vga_fb_prefetch_ctrl.sv
// Directed bench for vga_fb_prefetch_ctrl: 4x2 frame, 2-cycle memory, scoreboarded FIFO writes.
module tb_vga_fb_prefetch_ctrl;
  localparam int unsigned   AW   = 19;
  localparam int unsigned   DW   = 16;
  localparam int unsigned   FW   = 8;
  localparam int unsigned   MO   = 2;
  localparam logic [AW-1:0] BASE = 19'h7FFFD;
`ifdef VGA_FB_STAT_EN
  localparam bit Stat = 1'b1;
`else
  localparam bit Stat = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        rst_sys_n = 1'b0;
  logic        enable = 1'b0;
  logic        frame_start = 1'b0;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        err_ovf;

  vga_fb_prefetch_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  vga_fb_prefetch_ctrl #(
    .AW(AW), .DW(DW), .H_RES(4), .V_RES(2), .BASE_ADDR(BASE), .MAX_OUTSTD(MO)
  ) dut (
    .clk_sys     (clk_sys),
    .rst_sys_n   (rst_sys_n),
    .enable      (enable),
    .frame_start (frame_start),
    .bus         (bus),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .err_ovf     (err_ovf)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
  } pend_t;

  int            n_checks = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q[$];
  pend_t         pend_q[$];
  int unsigned   cyc = 0;
  bit            ret_en = 1'b1;
  bit            sb_en = 1'b1;
  logic [AW-1:0] exp_addr = BASE;
  int            acc_cnt = 0;
  int            wr_cnt = 0;
  int            exp_frames = 0;
  int            a0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  // Memory model: in-order returns two cycles after acceptance, gated by ret_en.
  initial begin
    pend_t p;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(posedge clk_sys);
      cyc++;
      if (rst_sys_n && bus.mem_req && bus.mem_ready)
        pend_q.push_back('{due: cyc + 1, data: mem_word(bus.mem_addr)});
      #2;
      bus.mem_rvalid = 1'b0;
      if (ret_en && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        p = pend_q.pop_front();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = p.data;
        if (sb_en) exp_q.push_back(p.data);
      end
    end
  end

  // Monitor: FIFO writes against the scoreboard, accepted addresses against the model.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (rst_sys_n) begin
        if (bus.fifo_write) begin
          wr_cnt++;
          chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) chk("fifo_din", 32'(bus.fifo_din), 32'(exp_q.pop_front()));
        end
        if (bus.mem_req && bus.mem_ready) begin
          chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
          exp_addr++;
          acc_cnt++;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
  endtask

  task automatic new_frame();
    acc_cnt  = 0;
    wr_cnt   = 0;
    exp_addr = BASE;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      step(1);
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50; i++) begin
      if (pend_q.size() == 0 && !bus.mem_rvalid) break;
      step(1);
    end
    chk("drain", 32'(pend_q.size()), 32'd0);
  endtask

  task automatic frame_end(input string tag);
    wait_idle({tag, "_idle"});
    step(2);
    exp_frames++;
    chk({tag, "_accepts"}, 32'(acc_cnt), FW);
    chk({tag, "_writes"}, 32'(wr_cnt), FW);
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), Stat ? 32'(exp_frames) : 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'(BASE));
    chk({tag, "_fifo_write"}, 32'(bus.fifo_write), 32'd0);
    chk({tag, "_fifo_din"}, 32'(bus.fifo_din), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    chk({tag, "_err_ovf"}, 32'(err_ovf), 32'd0);
  endtask

  initial begin
    bus.mem_ready  = 1'b1;
    bus.fifo_full  = 1'b0;
    bus.fifo_afull = 1'b0;
    step(3);
    chk_reset("rst");
    rst_sys_n = 1'b1;
    step(1);
    chk_reset("post_rst");

    // enable low blocks the start
    pulse_fs();
    step(3);
    chk("disabled_busy", 32'(busy), 32'd0);
    chk("disabled_accepts", 32'(acc_cnt), 32'd0);
    enable = 1'b1;

    // T1: full frame, address wraps past 2^AW
    new_frame();
    pulse_fs();
    chk("t1_busy", 32'(busy), 32'd1);
    frame_end("t1");

    // T2: no returns -> only MAX_OUTSTD accepted
    ret_en = 1'b0;
    new_frame();
    pulse_fs();
    step(20);
    chk("t2_accepts", 32'(acc_cnt), MO);
    chk("t2_mem_req", 32'(bus.mem_req), 32'd0);
    ret_en = 1'b1;
    frame_end("t2");

    // T3: afull throttles, release resumes at the next address
    new_frame();
    pulse_fs();
    for (int i = 0; i < 50 && acc_cnt < 2; i++) step(1);
    bus.fifo_afull = 1'b1;
    step(3);
    a0 = acc_cnt;
    step(10);
    chk("t3_frozen", 32'(acc_cnt), 32'(a0));
    chk("t3_mem_req", 32'(bus.mem_req), 32'd0);
    bus.fifo_afull = 1'b0;
    frame_end("t3");

    // T4: mid-frame resync flushes in-flight data then restarts at BASE
    new_frame();
    pulse_fs();
    for (int i = 0; i < 50 && acc_cnt < 3; i++) step(1);
    pulse_fs();
    sb_en = 1'b0;
    chk("t4_busy", 32'(busy), 32'd1);
    wait_drain();
    chk("t4_flushed", 32'(exp_q.size()), 32'd0);
    sb_en = 1'b1;
    new_frame();
    frame_end("t4");

    // T5: stalled request keeps address and valid stable
    bus.mem_ready = 1'b0;
    new_frame();
    pulse_fs();
    for (int i = 0; i < 10 && !bus.mem_req; i++) step(1);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t5_mem_req", 32'(bus.mem_req), 32'd1);
      chk("t5_mem_addr", 32'(bus.mem_addr), 32'(BASE));
    end
    bus.mem_ready = 1'b1;
    frame_end("t5");

    // T6: writes into a full FIFO set the sticky overflow flag
    new_frame();
    bus.fifo_full = 1'b1;
    pulse_fs();
    frame_end("t6");
    bus.fifo_full = 1'b0;
    chk("t6_err_ovf", 32'(err_ovf), Stat ? 32'd1 : 32'd0);
    step(5);
    chk("t6_err_sticky", 32'(err_ovf), Stat ? 32'd1 : 32'd0);

    // Reset with reads in flight; late returns must be ignored
    new_frame();
    pulse_fs();
    for (int i = 0; i < 50 && acc_cnt < 2; i++) step(1);
    rst_sys_n = 1'b0;
    sb_en = 1'b0;
    step(1);
    chk_reset("mid_rst");
    exp_q.delete();
    exp_frames = 0;
    rst_sys_n = 1'b1;
    wait_drain();
    chk("mid_rst_no_write", 32'(exp_q.size()), 32'd0);
    sb_en = 1'b1;
    new_frame();
    pulse_fs();
    frame_end("post_mid_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
